// File: rtl/ssd_mux_ctrl_if.sv
// Byte handshake between a producer and the 7-segment mux controller.
// The producer drives valid_i/data_i; the controller drives ready_o.
interface ssd_mux_ctrl_if;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ready_o;

  modport master (output valid_i, output data_i, input ready_o);
  modport slave  (input valid_i, input data_i, output ready_o);
endinterface

// File: rtl/ssd_mux_ctrl.sv
// Digit-select generator and frame-synchronous display register for a two-digit
// 7-segment driver; new bytes wait in a one-entry buffer until a frame boundary.
module ssd_mux_ctrl #(
  parameter int unsigned DIV_P       = 120000,
  parameter logic [7:0]  RESET_VAL_P = 8'h00
) (
  input  logic                clk_i,
  input  logic                reset_i,
  ssd_mux_ctrl_if.slave       bus,
  output logic                sel_o,
  output logic [3:0]          left_digit_o,
  output logic [3:0]          right_digit_o,
  output logic                frame_o
);

  localparam int unsigned CW = (DIV_P > 1) ? $clog2(DIV_P) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_P - 1);

  logic [CW-1:0] cnt;
  logic [7:0]    disp;
  logic [7:0]    pend;
  logic          pend_full;
  logic          wrap;
  logic          boundary;
  logic          accept;

  assign wrap        = (cnt == LAST);
  // Boundary = end of the left phase, so each frame starts on the right digit.
  assign boundary    = wrap & sel_o;
  assign bus.ready_o = ~pend_full;
  assign accept      = bus.valid_i & ~pend_full;

  assign left_digit_o  = disp[7:4];
  assign right_digit_o = disp[3:0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt       <= '0;
      sel_o     <= 1'b0;
      disp      <= RESET_VAL_P;
      pend      <= '0;
      pend_full <= 1'b0;
      frame_o   <= 1'b0;
    end else begin
      frame_o <= 1'b0;

      if (wrap) begin
        cnt   <= '0;
        sel_o <= ~sel_o;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Accept requires an empty buffer and commit a full one, so the two never collide.
      if (boundary && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
        frame_o   <= 1'b1;
      end else if (accept) begin
        pend      <= bus.data_i;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssd_mux_ctrl.sv
// Scoreboard bench for ssd_mux_ctrl: two instances (DIV_P=4 and DIV_P=2) driven
// cycle by cycle against a reference timing model.
module tb_ssd_mux_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       sel_a, sel_b, frame_a, frame_b;
  logic [3:0] left_a, right_a, left_b, right_b;

  ssd_mux_ctrl_if bus_a();
  ssd_mux_ctrl_if bus_b();

  ssd_mux_ctrl #(.DIV_P(4), .RESET_VAL_P(8'h00)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .bus(bus_a.slave), .sel_o(sel_a),
    .left_digit_o(left_a), .right_digit_o(right_a), .frame_o(frame_a)
  );

  ssd_mux_ctrl #(.DIV_P(2), .RESET_VAL_P(8'hF0)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .bus(bus_b.slave), .sel_o(sel_b),
    .left_digit_o(left_b), .right_digit_o(right_b), .frame_o(frame_b)
  );

  typedef struct {
    logic [7:0]  data;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    int unsigned start;
  } req_t;

  exp_t sb[$];
  req_t want[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam int unsigned NO_RST = 32'hFFFF_FFFF;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_rst(input int which, input logic v);
    if (which == 0) rst_a = v;
    else            rst_b = v;
  endtask

  task automatic drive(input int which, input logic v, input logic [7:0] d);
    if (which == 0) begin
      bus_a.valid_i = v;
      bus_a.data_i  = d;
    end else begin
      bus_b.valid_i = v;
      bus_b.data_i  = d;
    end
  endtask

  task automatic sample(input int which, output logic s, output logic [3:0] l,
                        output logic [3:0] r, output logic rdy, output logic f);
    if (which == 0) begin
      s = sel_a; l = left_a; r = right_a; rdy = bus_a.ready_o; f = frame_a;
    end else begin
      s = sel_b; l = left_b; r = right_b; rdy = bus_b.ready_o; f = frame_b;
    end
  endtask

  task automatic check_reset_state(input string pfx, input int which, input logic [7:0] rv);
    logic s, rdy, f;
    logic [3:0] l, r;
    sample(which, s, l, r, rdy, f);
    check({pfx, "_sel"},   32'(s),   0);
    check({pfx, "_left"},  32'(l),   32'(rv[7:4]));
    check({pfx, "_right"}, 32'(r),   32'(rv[3:0]));
    check({pfx, "_ready"}, 32'(rdy), 1);
    check({pfx, "_frame"}, 32'(f),   0);
  endtask

  // Runs ncyc cycles after reset on one instance; rst_at injects an async reset mid-cycle.
  task automatic run(input int which, input int unsigned d, input logic [7:0] rv,
                     input int unsigned ncyc, input int unsigned rst_at);
    int unsigned n = 0;
    int unsigned b;
    bit          rst_done = 0;
    logic [7:0]  exp_disp = rv;
    logic        exp_f;
    logic        s, rdy, f;
    logic [3:0]  l, r;

    sb.delete();
    drive(which, 1'b0, 8'h00);
    set_rst(which, 1'b1);
    repeat (2) @(negedge clk);
    check_reset_state("reset", which, rv);
    set_rst(which, 1'b0);

    for (int unsigned k = 0; k < ncyc; k++) begin
      if (!rst_done && n == rst_at) begin
        rst_done = 1;
        #2;
        set_rst(which, 1'b1);
        #1;
        check_reset_state("async_rst", which, rv);
        sb.delete();
        want.delete();
        exp_disp = rv;
        drive(which, 1'b0, 8'h00);
        @(negedge clk);
        set_rst(which, 1'b0);
        n = 0;
      end

      sample(which, s, l, r, rdy, f);
      exp_f = 1'b0;
      if (sb.size() > 0 && sb[0].due == n) begin
        exp_f    = 1'b1;
        exp_disp = sb[0].data;
        void'(sb.pop_front());
      end
      check("sel",   32'(s),   (n / d) % 2);
      check("frame", 32'(f),   32'(exp_f));
      check("left",  32'(l),   32'(exp_disp[7:4]));
      check("right", 32'(r),   32'(exp_disp[3:0]));
      check("ready", 32'(rdy), (sb.size() == 0) ? 1 : 0);

      if (want.size() > 0 && n >= want[0].start) begin
        drive(which, 1'b1, want[0].data);
        if (sb.size() == 0) begin
          b = n + 1;
          while (b % (2 * d) != 2 * d - 1) b++;
          sb.push_back('{data: want[0].data, due: b + 1});
          void'(want.pop_front());
        end
      end else begin
        drive(which, 1'b0, 8'($urandom));
      end

      @(negedge clk);
      n++;
    end
    check("sb_drained", sb.size(), 0);
    check("want_drained", want.size(), 0);
    drive(which, 1'b0, 8'h00);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    @(negedge clk);

    // Idle: select toggles 4/4, digits hold reset value, no frame pulses.
    run(0, 4, 8'h00, 20, NO_RST);

    // A5 commit at cycle 8; 3C then held 7E 8 cycles apart; 12 accepted in a boundary cycle.
    want.push_back('{data: 8'hA5, start: 1});
    want.push_back('{data: 8'h3C, start: 10});
    want.push_back('{data: 8'h7E, start: 10});
    want.push_back('{data: 8'h12, start: 31});
    run(0, 4, 8'h00, 45, NO_RST);

    // Async reset while 99 is pending and A5 is displayed; 99 must never appear.
    want.push_back('{data: 8'hA5, start: 1});
    want.push_back('{data: 8'h99, start: 9});
    run(0, 4, 8'h00, 40, 12);

    // DIV_P=2, RESET_VAL_P=F0: 4-cycle frame.
    want.push_back('{data: 8'h5A, start: 1});
    want.push_back('{data: 8'hC3, start: 2});
    want.push_back('{data: 8'h0F, start: 11});
    run(1, 2, 8'hF0, 30, NO_RST);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
